pe_db: RTL and testbench
========================

Name: pe_db

Overview:
- Next-generation weight-stationary processing element for the parametrised INT systolic array.
- Double-buffered (shadow/active) weight register: next tile's weights load systolically during compute.
- Clear-and-accumulate starts a new tile without a bubble.
- A registered drain chain shifts finished accumulators down the column while the next tile computes.

Parameters:
A_W, 8, activation width (signed)
W_W, 8, weight width (signed)
ACC_W, 32, accumulator width (signed); must be ≥ A_W+W_W
PIPE, 1, 1 = register a_out/a_valid_out; 0 = combinational pass-through

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
a_in  in  A_W  activation from west
a_valid_in  in  1  activation qualifier from west
b_in  in  W_W  weight from north (systolic load chain)
load_weight  in  1  capture b_in into shadow weight
swap  in  1  copy shadow weight into active weight
en  in  1  MAC enable
clr  in  1  sync accumulator clear
capture  in  1  copy acc into drain register
drain_in  in  ACC_W  drain data from north PE
drain_valid_in  in  1  drain qualifier from north
a_out  out  A_W  activation to east
a_valid_out  out  1  activation qualifier to east
b_out  out  W_W  weight to south (registered b_in)
load_weight_out  out  1  registered load_weight to south
acc  out  ACC_W  accumulator
drain_out  out  ACC_W  drain data to south
drain_valid_out  out  1  drain qualifier to south
sat_flag  out  1  sticky overflow indicator

Behaviour:
- Reset: all outputs and internal registers 0. Reset mid-tile discards shadow, active, acc and drain contents; there is no partial recovery.
- Weight load:
  - b_out <= b_in and load_weight_out <= load_weight every cycle (1-cycle systolic hop).
  - load_weight=1: shadow <= b_in.
- Swap:
  - swap=1: active <= shadow.
  - swap and load_weight in the same cycle: active takes the OLD shadow; shadow takes b_in.
- MAC:
  - mac_go = en & a_valid_in.
  - product = a_in * active, signed, A_W+W_W bits, sign-extended to ACC_W.
  - The MAC uses the active value registered before the edge; swap in the same cycle affects the next cycle only.
  - load_weight together with en is legal: shadow is isolated from the MAC.
- Accumulate priority, per edge:
  - clr & mac_go: acc <= product.
  - clr only: acc <= 0.
  - mac_go only: acc <= acc + product.
  - neither: hold.
  - Latency: acc reflects an operand one cycle after its mac_go cycle.
- Activation path:
  - PIPE=1: a_out/a_valid_out registered, 1-cycle latency.
  - PIPE=0: a_out/a_valid_out combinational from a_in/a_valid_in.
  - The path forwards regardless of en.
- Drain:
  - capture=1: drain_out <= acc (pre-edge value), drain_valid_out <= 1.
  - Otherwise: drain_out <= drain_in, drain_valid_out <= drain_valid_in.
  - capture with clr (or clr & mac_go) in the same cycle: drain gets the finished tile, acc starts the new one (back-to-back tiles).
  - capture with drain_valid_in=1: capture wins, upstream data is lost. This is a scheduler protocol violation; the simulation assertion fires.
- Arithmetic overflow: behaviour is set by PE_SAT_EN (below).
- sat_flag:
  - Set on any saturating event.
  - Cleared only by clr, or by reset.
  - When clr and saturation coincide (clr & mac_go cannot overflow), clr dominates.
- Assertions (simulation only):
  - capture implies !drain_valid_in.
  - swap implies at least one load_weight since reset.
  - ACC_W ≥ A_W+W_W (elaboration check).

Optional Feature:
- Macro PE_SAT_EN.
- Defined: acc + product is computed at ACC_W+1 bits.
  - If the result exceeds the signed ACC_W range, acc clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and sat_flag is set.
- Undefined: two's-complement wrap; sat_flag is tied 0.

Test Plan:
1. Reset/load/swap/MAC:
   - Reset, then load_weight with b_in=5; next cycle b_out=5 and load_weight_out=1.
   - swap; then en/a_valid_in with a_in=3 for 4 cycles -> acc=60.
   - With PIPE=1, a_out follows a_in by 1 cycle.
2. Load during compute:
   - Active=2, stream a_in=1 for 6 cycles; in cycle 3 load b_in=-7 -> acc=12 (unaffected).
   - Then swap, a_in=1 for one cycle -> acc=5.
3. Swap timing:
   - swap with en in the same cycle, old active=4, shadow=-1, a_in=10 -> acc=+40 that cycle.
   - Next cycle a_in=10 -> acc=30.
4. Back-to-back tiles:
   - acc=100; assert capture+clr+en with a_in=2, active=3 -> drain_out=100, drain_valid_out=1, acc=6 next cycle.
   - Drain value appears on the south neighbour one cycle later.
5. Saturation, PE_SAT_EN defined, ACC_W=32:
   - active=127, a_in=127 repeatedly from acc=0x7FFF_0000 -> acc clamps to 0x7FFF_FFFF and sat_flag=1.
   - Flag holds until clr.
   - Without the macro, the same stimulus wraps negative and sat_flag=0.
6. Corner cases:
   - Reset mid-accumulation -> all outputs 0 immediately (async).
   - a_valid_in=0 with en=1 -> acc holds.
   - capture with drain_valid_in=1 -> assertion fires.

Source files
------------

// File: rtl/pe_db.sv
// pe_db: weight-stationary INT processing element with a double-buffered
// (shadow/active) weight, clear-and-accumulate for bubble-free tile changes,
// and a registered drain chain for finished accumulators.
// Optional feature macro: PE_SAT_EN (saturating accumulate plus sticky sat_flag).
// Without it the accumulator wraps in two's complement and sat_flag stays 0.
module pe_db #(
    parameter int unsigned A_W   = 8,
    parameter int unsigned W_W   = 8,
    parameter int unsigned ACC_W = 32,
    parameter int unsigned PIPE  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [A_W-1:0]   a_in,
    input  logic             a_valid_in,
    input  logic [W_W-1:0]   b_in,
    input  logic             load_weight,
    input  logic             swap,
    input  logic             en,
    input  logic             clr,
    input  logic             capture,
    input  logic [ACC_W-1:0] drain_in,
    input  logic             drain_valid_in,
    output logic [A_W-1:0]   a_out,
    output logic             a_valid_out,
    output logic [W_W-1:0]   b_out,
    output logic             load_weight_out,
    output logic [ACC_W-1:0] acc,
    output logic [ACC_W-1:0] drain_out,
    output logic             drain_valid_out,
    output logic             sat_flag
);

    localparam int unsigned PROD_W = A_W + W_W;
    localparam int unsigned SUM_W  = ACC_W + 1;

    logic [W_W-1:0]   b_q;
    logic             lw_q;
    logic [W_W-1:0]   shadow_q, shadow_d;
    logic [W_W-1:0]   active_q, active_d;
    logic             loaded_q, loaded_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] drain_q, drain_d;
    logic             drain_valid_q, drain_valid_d;
    logic             sat_q, sat_d;

    logic                     mac_go;
    logic signed [PROD_W-1:0] a_ext, w_ext, prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]         sum;
    logic                     ovf;

    // Signed product of the activation and the pre-edge active weight
    assign mac_go   = en & a_valid_in;
    assign a_ext    = PROD_W'($signed(a_in));
    assign w_ext    = PROD_W'($signed(active_q));
    assign prod     = a_ext * w_ext;
    assign prod_ext = ACC_W'(prod);

`ifdef PE_SAT_EN
    logic signed [SUM_W-1:0] sum_wide;

    // One guard bit detects leaving the signed ACC_W range; clamp toward the overflow side
    assign sum_wide = SUM_W'($signed(acc_q)) + SUM_W'(prod_ext);
    assign ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    assign sum      = !ovf            ? sum_wide[ACC_W-1:0] :
                      sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                        {1'b0, {(ACC_W-1){1'b1}}};
`else
    // Plain two's-complement wrap
    assign sum = acc_q + prod_ext;
    assign ovf = 1'b0;
`endif

    // Next-state for weights, accumulator, flag and drain chain
    always_comb begin
        shadow_d      = shadow_q;
        active_d      = active_q;
        loaded_d      = loaded_q;
        acc_d         = acc_q;
        sat_d         = sat_q;
        drain_d       = drain_in;
        drain_valid_d = drain_valid_in;

        if (load_weight) begin
            shadow_d = b_in;
            loaded_d = 1'b1;
        end
        if (swap) begin
            active_d = shadow_q;
        end

        if (clr && mac_go) begin
            acc_d = prod_ext;
            sat_d = 1'b0;
        end else if (clr) begin
            acc_d = '0;
            sat_d = 1'b0;
        end else if (mac_go) begin
            acc_d = sum;
            if (ovf) begin
                sat_d = 1'b1;
            end
        end

        if (capture) begin
            drain_d       = acc_q;
            drain_valid_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q           <= '0;
            lw_q          <= 1'b0;
            shadow_q      <= '0;
            active_q      <= '0;
            loaded_q      <= 1'b0;
            acc_q         <= '0;
            drain_q       <= '0;
            drain_valid_q <= 1'b0;
            sat_q         <= 1'b0;
        end else begin
            b_q           <= b_in;
            lw_q          <= load_weight;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            loaded_q      <= loaded_d;
            acc_q         <= acc_d;
            drain_q       <= drain_d;
            drain_valid_q <= drain_valid_d;
            sat_q         <= sat_d;
        end
    end

    assign b_out           = b_q;
    assign load_weight_out = lw_q;
    assign acc             = acc_q;
    assign drain_out       = drain_q;
    assign drain_valid_out = drain_valid_q;
    assign sat_flag        = sat_q;

    // Activation forwarding east, independent of en
    if (PIPE != 0) begin : g_a_pipe
        logic [A_W-1:0] a_q;
        logic           av_q;

        // One-cycle registered hop
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q  <= '0;
                av_q <= 1'b0;
            end else begin
                a_q  <= a_in;
                av_q <= a_valid_in;
            end
        end

        assign a_out       = a_q;
        assign a_valid_out = av_q;
    end else begin : g_a_comb
        assign a_out       = a_in;
        assign a_valid_out = a_valid_in;
    end

    // Accumulator must hold a full product
    if (ACC_W < PROD_W) begin : g_acc_w_check
        $error("pe_db: ACC_W must be at least A_W+W_W");
    end

`ifndef SYNTHESIS
    // Scheduler protocol checks
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(capture && drain_valid_in))
                else $error("pe_db: capture while drain_valid_in set, upstream drain data lost");
            assert (!swap || loaded_q)
                else $error("pe_db: swap before any load_weight since reset");
        end
    end
`endif

endmodule

// File: tb/tb_pe_db.sv
// Scoreboard bench for pe_db: a default instance (ACC_W=32, PIPE=1) and a
// 16-bit, PIPE=0 instance that shares the stimulus and sits south of it on
// the drain chain, so saturation and drain forwarding are reachable quickly.
module tb_pe_db;

`ifdef PE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  a_in = '0;
    logic        a_valid_in = 1'b0;
    logic [7:0]  b_in = '0;
    logic        load_weight = 1'b0;
    logic        swap = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        capture = 1'b0;
    logic [31:0] drain_in = '0;
    logic        drain_valid_in = 1'b0;

    logic [7:0]  a_out, a_out_s, b_out, b_out_s;
    logic        a_valid_out, a_valid_out_s, lw_out, lw_out_s;
    logic [31:0] acc, drain_out;
    logic [15:0] acc_s, drain_out_s;
    logic        drain_valid_out, drain_valid_out_s, sat_flag, sat_s;

    pe_db #(.A_W(8), .W_W(8), .ACC_W(32), .PIPE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .a_in(a_in), .a_valid_in(a_valid_in),
        .b_in(b_in), .load_weight(load_weight), .swap(swap), .en(en), .clr(clr),
        .capture(capture), .drain_in(drain_in), .drain_valid_in(drain_valid_in),
        .a_out(a_out), .a_valid_out(a_valid_out), .b_out(b_out),
        .load_weight_out(lw_out), .acc(acc), .drain_out(drain_out),
        .drain_valid_out(drain_valid_out), .sat_flag(sat_flag)
    );

    pe_db #(.A_W(8), .W_W(8), .ACC_W(16), .PIPE(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .a_in(a_in), .a_valid_in(a_valid_in),
        .b_in(b_in), .load_weight(load_weight), .swap(swap), .en(en), .clr(clr),
        .capture(capture), .drain_in(drain_out[15:0]), .drain_valid_in(drain_valid_out),
        .a_out(a_out_s), .a_valid_out(a_valid_out_s), .b_out(b_out_s),
        .load_weight_out(lw_out_s), .acc(acc_s), .drain_out(drain_out_s),
        .drain_valid_out(drain_valid_out_s), .sat_flag(sat_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        int unsigned due;
        logic [31:0] val;
    } exp_t;

    exp_t        eq[$];
    logic [7:0]  act_q[$];
    logic [31:0] dm_q[$];
    logic [15:0] ds_q[$];
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    // Expect a value to be visible after the next clock edge
    task automatic expect_v(input int id, input logic [31:0] val);
        exp_t e;
        e.id  = id;
        e.due = cyc + 1;
        e.val = val;
        eq.push_back(e);
    endtask

    // Apply the currently set inputs for one edge, then return to idle
    task automatic step();
        if (a_valid_in) act_q.push_back(a_in);
        @(posedge clk);
        #1;
        a_in = '0; a_valid_in = 1'b0; b_in = '0; load_weight = 1'b0; swap = 1'b0;
        en = 1'b0; clr = 1'b0; capture = 1'b0; drain_in = '0; drain_valid_in = 1'b0;
    endtask

    task automatic mac(input logic [7:0] a);
        en = 1'b1; a_valid_in = 1'b1; a_in = a;
    endtask

    // Monitor: pops cycle-tagged expectations and valid-qualified streams
    exp_t        m_e;
    logic [31:0] m_got;
    string       m_name;
    always @(negedge clk) begin
        while (eq.size() != 0 && eq[0].due <= cyc) begin
            m_e = eq.pop_front();
            case (m_e.id)
                0:       begin m_got = acc;                     m_name = "acc";      end
                1:       begin m_got = {31'b0, sat_flag};       m_name = "sat_flag"; end
                2:       begin m_got = {24'b0, b_out};          m_name = "b_out";    end
                3:       begin m_got = {31'b0, lw_out};         m_name = "lw_out";   end
                4:       begin m_got = {16'b0, acc_s};          m_name = "acc16";    end
                default: begin m_got = {31'b0, sat_s};          m_name = "sat16";    end
            endcase
            if (m_e.due != cyc) chk({m_name, "_late"}, cyc, m_e.due);
            else                chk(m_name, m_got, m_e.val);
        end
        if (a_valid_out) begin
            if (act_q.size() == 0) chk("a_valid_out_spurious", 32'(a_valid_out), 32'd0);
            else                   chk("a_out", 32'(a_out), 32'(act_q.pop_front()));
        end
        if (a_valid_in) begin
            chk("a_out_comb", {23'b0, a_valid_out_s, a_out_s}, {23'b0, a_valid_in, a_in});
        end
        if (drain_valid_out) begin
            if (dm_q.size() == 0) chk("drain_valid_spurious", 32'(drain_valid_out), 32'd0);
            else                  chk("drain_out", drain_out, dm_q.pop_front());
        end
        if (drain_valid_out_s) begin
            if (ds_q.size() == 0) chk("drain16_valid_spurious", 32'(drain_valid_out_s), 32'd0);
            else                  chk("drain16_out", 32'(drain_out_s), 32'(ds_q.pop_front()));
        end
    end

    initial begin
        // Reset state
        #12;
        chk("rst_acc", acc, 32'd0);
        chk("rst_outs", {28'b0, a_valid_out, drain_valid_out, sat_flag, lw_out}, 32'd0);
        chk("rst_b_out", 32'(b_out), 32'd0);
        chk("rst_drain", drain_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: load, swap, MAC
        b_in = 8'd5; load_weight = 1'b1; expect_v(2, 5); expect_v(3, 1); step();
        swap = 1'b1; expect_v(2, 0); expect_v(3, 0); step();
        for (int i = 1; i <= 4; i++) begin
            mac(8'd3); expect_v(0, 32'(15 * i)); expect_v(4, 32'(15 * i)); step();
        end
        clr = 1'b1; expect_v(0, 0); step();

        // 2: load during compute
        b_in = 8'd2; load_weight = 1'b1; step();
        swap = 1'b1; step();
        for (int i = 1; i <= 6; i++) begin
            mac(8'd1);
            if (i == 3) begin
                b_in = 8'hF9; load_weight = 1'b1; expect_v(2, 32'hF9);
            end
            expect_v(0, 32'(2 * i)); step();
        end
        swap = 1'b1; expect_v(0, 12); step();
        mac(8'd1); expect_v(0, 5); step();
        en = 1'b1; a_in = 8'd9; expect_v(0, 5); step();

        // 3: swap timing, with swap+load in one cycle
        clr = 1'b1; b_in = 8'd4; load_weight = 1'b1; expect_v(0, 0); step();
        b_in = 8'hFF; load_weight = 1'b1; swap = 1'b1; step();
        swap = 1'b1; mac(8'd10); expect_v(0, 40); expect_v(4, 40); step();
        mac(8'd10); expect_v(0, 30); expect_v(4, 30); step();

        // 4: back-to-back tiles and drain chain
        b_in = 8'd10; load_weight = 1'b1; step();
        swap = 1'b1; step();
        clr = 1'b1; mac(8'd10); b_in = 8'd3; load_weight = 1'b1; expect_v(0, 100); step();
        swap = 1'b1; expect_v(0, 100); step();
        capture = 1'b1; clr = 1'b1; mac(8'd2); expect_v(0, 6); expect_v(4, 6);
        dm_q.push_back(32'd100); ds_q.push_back(16'd100); step();
        drain_in = 32'h1234; drain_valid_in = 1'b1;
        dm_q.push_back(32'h1234); ds_q.push_back(16'd100); step();
        ds_q.push_back(16'h1234); step();
        step();

        // 5: positive overflow on the 16-bit instance
        clr = 1'b1; b_in = 8'h80; load_weight = 1'b1; expect_v(0, 0); expect_v(5, 0); step();
        swap = 1'b1; step();
        mac(8'h80); expect_v(0, 16384); expect_v(4, 16384); step();
        mac(8'h80); expect_v(0, 32768); expect_v(4, SAT ? 32'h7FFF : 32'h8000);
        expect_v(5, 32'(SAT)); expect_v(1, 0); step();
        expect_v(4, SAT ? 32'h7FFF : 32'h8000); expect_v(5, 32'(SAT)); step();
        mac(8'h80); expect_v(0, 49152); expect_v(4, SAT ? 32'h7FFF : 32'hC000);
        expect_v(5, 32'(SAT)); step();
        clr = 1'b1; b_in = 8'd127; load_weight = 1'b1;
        expect_v(0, 0); expect_v(4, 0); expect_v(5, 0); step();
        swap = 1'b1; step();
        // negative overflow
        mac(8'h80); expect_v(0, 32'hFFFF_C080); expect_v(4, 32'hC080); step();
        mac(8'h80); expect_v(0, 32'hFFFF_8100); expect_v(4, 32'h8100); step();
        mac(8'h80); expect_v(0, 32'hFFFF_4180); expect_v(4, SAT ? 32'h8000 : 32'h4180);
        expect_v(5, 32'(SAT)); expect_v(1, 0); step();
        clr = 1'b1; mac(8'd1); expect_v(0, 127); expect_v(4, 127); expect_v(5, 0); step();

        // 6: asynchronous reset mid-accumulation
        mac(8'd1); expect_v(0, 254); step();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_acc", acc, 32'd0);
        chk("arst_acc16", 32'(acc_s), 32'd0);
        chk("arst_flags", {28'b0, a_valid_out, drain_valid_out, sat_flag, lw_out}, 32'd0);
        chk("arst_b_out", 32'(b_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mac(8'd7); expect_v(0, 0); step();
        step();

        for (int k = 0; k < 20 && (eq.size() + act_q.size() + dm_q.size() + ds_q.size()) != 0; k++) begin
            @(negedge clk);
        end
        chk("queues_drained", 32'(eq.size() + act_q.size() + dm_q.size() + ds_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
